// File: rtl/inst_pkg.sv
// Shared definitions for the core instruction sequencer: inst word layout,
// the idle word, and the sequencer FSM state encoding.
package inst_pkg;

  localparam int unsigned INST_W = 34;
  localparam int unsigned A_W    = 11;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned B_ACC      = 33;
  localparam int unsigned B_CEN_P    = 32;
  localparam int unsigned B_WEN_P    = 31;
  localparam int unsigned B_AP_LO    = 20;
  localparam int unsigned B_CEN_X    = 19;
  localparam int unsigned B_WEN_X    = 18;
  localparam int unsigned B_AX_LO    = 7;
  localparam int unsigned B_OFIFO_RD = 6;
  localparam int unsigned B_IFIFO_WR = 5;
  localparam int unsigned B_IFIFO_RD = 4;
  localparam int unsigned B_L0_RD    = 3;
  localparam int unsigned B_L0_WR    = 2;
  localparam int unsigned B_EXEC     = 1;
  localparam int unsigned B_LOAD     = 0;

  // Both SRAMs deselected and write-disabled, everything else quiet.
  localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    IDLE,
    W_L0,
    W_GAP1,
    W_LOAD,
    GAP,
    A_L0,
    A_GAP,
    EXEC,
    E_GAP,
    OF_RD,
    FIN,
    ACC_CLR,
    ACC_RD,
    ACC_TAIL
  } state_e;

endpackage

// File: rtl/acc_addr_gen.sv
// Psum SRAM address for output pixel o, kernel tap k during accumulation.
// Output is registered; feed it next-cycle o/k so it lines up with the FSM.
module acc_addr_gen #(
  parameter int unsigned len_nij = 36,
  parameter int unsigned in_w    = 6,
  parameter int unsigned out_w   = 4,
  parameter int unsigned aw      = 11,
  parameter int unsigned ow      = 5,
  parameter int unsigned kw      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [ow-1:0] o_i,
  input  logic [kw-1:0] k_i,
  output logic [aw-1:0] addr_o
);

  logic [31:0]   sum;
  logic [aw-1:0] addr_d, addr_q;

  always_comb begin
    sum = 32'(k_i) * len_nij
        + (32'(o_i) / out_w + 32'(k_i) / 3) * in_w
        + (32'(o_i) % out_w + 32'(k_i) % 3);
    addr_d = sum[aw-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/inst_sequencer.sv
// Generates the core instruction stream for one kij pass or for the final
// accumulation pass over all output pixels; inst feeds core.inst directly.
module inst_sequencer
  import inst_pkg::*;
#(
  parameter int unsigned row      = 8,
  parameter int unsigned col      = 8,
  parameter int unsigned len_nij  = 36,
  parameter int unsigned in_w     = 6,
  parameter int unsigned out_w    = 4,
  parameter int unsigned len_kij  = 9,
  parameter int unsigned len_onij = 16,
  parameter int unsigned aw       = 11,
  parameter int unsigned w_base   = 1024,
  parameter int unsigned gap      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [3:0]        kij,
  output logic [INST_W-1:0] inst,
  output logic              acc_clr,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned L_WL0   = 2 * col + 1;
  localparam int unsigned L_WLOAD = row + 3 * col;
  localparam int unsigned L_GAP   = gap + 1;
  localparam int unsigned L_AL0   = 2 * len_nij + 1;
  localparam int unsigned L_EXEC  = 2 * len_nij + row + col;
  localparam int unsigned L_OFRD  = len_nij;
  localparam int unsigned L_ACCRD = len_kij;
  localparam int unsigned OW      = $clog2(len_onij + 1);
  localparam int unsigned KW      = $clog2(len_kij + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [3:0]          kij_q, kij_d;
  logic [OW-1:0]       o_q, o_d;
  logic [KW-1:0]       k_q, k_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                acc_clr_q, acc_clr_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [aw-1:0]       acc_addr;

  function automatic logic is_last(input logic [CNT_W-1:0] c, input int unsigned len);
    return 32'(c) == len - 1;
  endfunction

  function automatic logic [A_W-1:0] fld(input logic [31:0] v);
    logic [aw-1:0] t;
    t = v[aw-1:0];
    return A_W'(t);
  endfunction

  acc_addr_gen #(
    .len_nij (len_nij),
    .in_w    (in_w),
    .out_w   (out_w),
    .aw      (aw),
    .ow      (OW),
    .kw      (KW)
  ) u_addr (
    .clk    (clk),
    .reset  (reset),
    .o_i    (o_d),
    .k_i    (k_d),
    .addr_o (acc_addr)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    kij_d       = kij_q;
    o_d         = o_q;
    inst_d      = IDLE_WORD;
    acc_clr_d   = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // busy_q is still high during the done cycle, which blocks a start there
        if (start && !busy_q) begin
          if (mode) begin
            mode_d  = 1'b1;
            o_d     = '0;
            state_d = ACC_CLR;
          end else if (32'(kij) >= len_kij) begin
            err_d = 1'b1;
          end else begin
            mode_d  = 1'b0;
            kij_d   = kij;
            state_d = W_L0;
          end
        end
      end
      W_L0: begin
        inst_d[B_IFIFO_WR]         = 1'b1;
        inst_d[B_CEN_X]            = 1'b0;
        inst_d[B_AX_LO +: A_W]     = fld(w_base + 32'(cnt_q));
        if (is_last(cnt_q, L_WL0)) state_d = W_GAP1;
      end
      W_GAP1: state_d = W_LOAD;
      W_LOAD: begin
        inst_d[B_IFIFO_RD] = 1'b1;
        inst_d[B_LOAD]     = 1'b1;
        if (is_last(cnt_q, L_WLOAD)) state_d = GAP;
      end
      GAP: if (is_last(cnt_q, L_GAP)) state_d = A_L0;
      A_L0: begin
        inst_d[B_L0_WR]        = 1'b1;
        inst_d[B_CEN_X]        = 1'b0;
        inst_d[B_AX_LO +: A_W] = fld(32'(cnt_q));
        if (is_last(cnt_q, L_AL0)) state_d = A_GAP;
      end
      A_GAP: state_d = EXEC;
      EXEC: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_EXEC]  = 1'b1;
        if (is_last(cnt_q, L_EXEC)) state_d = E_GAP;
      end
      E_GAP: state_d = OF_RD;
      OF_RD: begin
        inst_d[B_OFIFO_RD]     = 1'b1;
        inst_d[B_CEN_P]        = 1'b0;
        inst_d[B_WEN_P]        = 1'b0;
        inst_d[B_AP_LO +: A_W] = fld(len_nij * 32'(kij_q) + 32'(cnt_q));
        if (is_last(cnt_q, L_OFRD)) state_d = FIN;
      end
      FIN: begin
        done_d      = 1'b1;
        out_valid_d = mode_q;
        state_d     = IDLE;
      end
      ACC_CLR: begin
        acc_clr_d   = 1'b1;
        out_valid_d = (o_q != '0);
        state_d     = ACC_RD;
      end
      ACC_RD: begin
        inst_d[B_CEN_P]        = 1'b0;
        inst_d[B_AP_LO +: A_W] = fld(32'(acc_addr));
        inst_d[B_ACC]          = (k_q != '0);
        if (is_last(cnt_q, L_ACCRD)) state_d = ACC_TAIL;
      end
      ACC_TAIL: begin
        inst_d[B_ACC] = 1'b1;
        if (32'(o_q) == len_onij - 1) begin
          state_d = FIN;
        end else begin
          o_d     = o_q + 1'b1;
          state_d = ACC_CLR;
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_d  = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    k_d    = (state_q == ACC_RD && state_d == ACC_RD) ? k_q + 1'b1 : '0;
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      kij_q       <= '0;
      o_q         <= '0;
      k_q         <= '0;
      inst_q      <= IDLE_WORD;
      acc_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      kij_q       <= kij_d;
      o_q         <= o_d;
      k_q         <= k_d;
      inst_q      <= inst_d;
      acc_clr_q   <= acc_clr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign inst      = inst_q;
  assign acc_clr   = acc_clr_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: reset, rejected start, kij pass,
// ignored starts and a full accumulation pass against hand-computed values.
module tb_inst_sequencer;
  import inst_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode  = 1'b0;
  logic [3:0]  kij   = '0;
  logic [33:0] inst;
  logic        acc_clr, out_valid, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [33:0] WL0_FIRST  = 34'h1_8006_0020;
  localparam logic [33:0] WLOAD_WORD = 34'h1_800C_0011;
  localparam logic [33:0] EXEC_WORD  = 34'h1_800C_000A;
  localparam logic [33:0] OFRD_FIRST = 34'h0_048C_0040;
  localparam logic [33:0] ACCRD_O0K0 = 34'h0_800C_0000;
  localparam logic [33:0] ACC_TAILW  = 34'h3_800C_0000;

  inst_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .kij       (kij),
    .inst      (inst),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int          c_ifw, c_load, c_exe, c_l0w, c_of, c_done, c_ov, c_clr, late_busy;
  int          done_c, acc5, bad_space;
  logic [10:0] first_ax, last_ax, last_l0_ax, first_ap, last_ap;
  int unsigned ap[$];
  int          ov[$];
  int unsigned exp5 [9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};

  initial begin
    #2 reset = 1'b0;
    repeat (3) step();
    chk("rst_inst", inst, IDLE_WORD);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ov", out_valid, 0);
    reset = 1'b1;
    step();

    // kij out of range: rejected with err
    start = 1'b1; mode = 1'b0; kij = 4'd9;
    step();
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_inst", inst, IDLE_WORD);
    step();
    chk("err_one_cycle", err, 0);
    chk("err_busy_after", busy, 0);

    // reset asserted in the middle of EXEC
    start = 1'b1; mode = 1'b0; kij = 4'd1;
    step();
    start = 1'b0;
    repeat (150) step();
    chk("pre_rst_exec_word", inst, EXEC_WORD);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_inst", inst, IDLE_WORD);
    chk("rst_async_busy", busy, 0);
    step();
    step();
    reset = 1'b1;
    c_done = 0;
    repeat (5) begin
      step();
      if (done) c_done++;
    end
    chk("rst_rel_inst", inst, IDLE_WORD);
    chk("rst_rel_busy", busy, 0);
    chk("rst_rel_no_done", c_done, 0);

    // kij pass, kij=2, with stray starts during busy and on the done cycle
    start = 1'b1; mode = 1'b0; kij = 4'd2;
    step();
    start = 1'b0;
    chk("kij_busy", busy, 1);
    c_ifw = 0; c_load = 0; c_exe = 0; c_l0w = 0; c_of = 0; c_done = 0;
    c_ov = 0; c_clr = 0; late_busy = 0; done_c = 0;
    first_ax = '0; last_ax = '0; last_l0_ax = '0; first_ap = '0; last_ap = '0;
    for (int c = 1; c <= 270; c++) begin
      step();
      start = 1'b0;
      if (c == 1)   chk("wl0_first_word", inst, WL0_FIRST);
      if (c == 19)  chk("wload_word", inst, WLOAD_WORD);
      if (c == 136) chk("exec_first_word", inst, EXEC_WORD);
      if (c == 225) chk("ofrd_first_word", inst, OFRD_FIRST);
      if (inst[5]) begin
        if (c_ifw == 0) first_ax = inst[17:7];
        last_ax = inst[17:7];
        c_ifw++;
      end
      if (inst[0]) c_load++;
      if (inst[1]) c_exe++;
      if (inst[2]) begin
        c_l0w++;
        last_l0_ax = inst[17:7];
      end
      if (inst[6]) begin
        if (c_of == 0) first_ap = inst[30:20];
        last_ap = inst[30:20];
        c_of++;
      end
      if (out_valid) c_ov++;
      if (acc_clr) c_clr++;
      if (c >= 262 && busy) late_busy++;
      if (done) begin
        c_done++;
        done_c = c;
        start = 1'b1; mode = 1'b1;
      end
      if (c == 100) begin
        start = 1'b1; mode = 1'b1;
      end
    end
    chk("ififo_wr_cycles", c_ifw, 17);
    chk("ax_first", first_ax, 1024);
    chk("ax_last", last_ax, 1040);
    chk("load_cycles", c_load, 32);
    chk("l0_wr_cycles", c_l0w, 73);
    chk("l0_ax_last", last_l0_ax, 72);
    chk("execute_cycles", c_exe, 88);
    chk("ofifo_rd_cycles", c_of, 36);
    chk("of_ap_first", first_ap, 72);
    chk("of_ap_last", last_ap, 107);
    chk("kij_done_count", c_done, 1);
    chk("kij_done_cycle", done_c, 261);
    chk("kij_no_out_valid", c_ov, 0);
    chk("stray_start_no_acc", c_clr, 0);
    chk("busy_after_done", late_busy, 0);
    chk("kij_end_inst", inst, IDLE_WORD);

    // full accumulation pass
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    chk("acc_busy", busy, 1);
    c_done = 0; done_c = 0; c_clr = 0; acc5 = 0; bad_space = 0;
    for (int c = 1; c <= 185; c++) begin
      step();
      if (c == 1)  chk("acc_clr_first", acc_clr, 1);
      if (c == 2)  chk("accrd_o0k0_word", inst, ACCRD_O0K0);
      if (c == 66) chk("acc_tail_word", inst, ACC_TAILW);
      if (!inst[32]) ap.push_back(int'(inst[30:20]));
      if (out_valid) begin
        if (ov.size() > 0 && c - ov[ov.size()-1] != 11) bad_space++;
        ov.push_back(c);
      end
      if (done) begin
        c_done++;
        done_c = c;
      end
      if (acc_clr) c_clr++;
      if (c >= 56 && c <= 66 && inst[33]) acc5++;
    end
    chk("acc_reads", ap.size(), 144);
    if (ap.size() >= 54)
      for (int k = 0; k < 9; k++) chk($sformatf("o5_addr_k%0d", k), ap[45+k], exp5[k]);
    if (ap.size() > 0) chk("acc_last_addr", ap[ap.size()-1], 323);
    chk("o5_acc_cycles", acc5, 9);
    chk("out_valid_count", ov.size(), 16);
    if (ov.size() > 0) begin
      chk("out_valid_first", ov[0], 12);
      chk("out_valid_last", ov[ov.size()-1], 177);
    end
    chk("out_valid_spacing", bad_space, 0);
    chk("acc_clr_count", c_clr, 16);
    chk("acc_done_count", c_done, 1);
    chk("acc_done_cycle", done_c, 177);
    chk("acc_end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Hardware replacement for the hand-scripted instruction stream that drives core.
- Generates the 34-bit inst word for one kij pass: weight SRAM→ififo, PE load, activation SRAM→L0, execute, ofifo→psum SRAM.
- Also runs the final accumulation pass over all output pixels, computing psum addresses on chip instead of reading an address file.
- Sits directly upstream of core; its inst output connects to core.inst.

Parameters:
- row, 8, PE rows (input channels)
- col, 8, PE columns (output channels)
- len_nij, 36, input pixels per tile (in_w*in_w)
- in_w, 6, input tile width
- out_w, 4, output tile width (in_w-2)
- len_kij, 9, kernel taps (3x3)
- len_onij, 16, output pixels
- aw, 11, xmem/pmem address width
- w_base, 1024, xmem base address of weights
- gap, 10, extra idle cycles after kernel load

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset (0 = reset)
- start  in  1  one-cycle pulse; sampled only in IDLE
- mode  in  1  0 = kij pass, 1 = accumulation pass; sampled with start
- kij  in  4  kernel tap index; sampled with start
- inst  out  34  core instruction word, registered
- acc_clr  out  1  one-cycle clear of the SFU accumulator
- out_valid  out  1  one-cycle pulse: sfp_out holds a finished pixel
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at pass end
- err  out  1  one-cycle pulse: start with mode=0 and kij>=len_kij; the start is rejected

Behaviour:
- inst fields:
  - [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- IDLE word: CEN_* = 1, WEN_* = 1, all other bits 0.
- Reset values: inst = IDLE word, all other outputs 0, FSM in IDLE.
- Latency: start is sampled at edge N; the first phase word appears after edge N+1.
- kij pass states, each phase t counting from 0:
  - W_L0, 2*col+1 cycles: ififo_wr=1, CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+t.
  - IDLE word, 1 cycle.
  - W_LOAD, row+3*col cycles: ififo_rd=1, load=1.
  - GAP, gap+1 cycles of IDLE word.
  - A_L0, 2*len_nij+1 cycles: l0_wr=1, CEN_xmem=0, WEN_xmem=1, A_xmem=t.
  - IDLE word, 1 cycle.
  - EXEC, 2*len_nij+row+col cycles: l0_rd=1, execute=1.
  - IDLE word, 1 cycle.
  - OF_RD, len_nij cycles: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=len_nij*kij+t.
  - IDLE word, 1 cycle, with done=1.
  - Total: 261 cycles at default parameters.
- Accumulation pass: for each o in 0..len_onij-1:
  - ACC_CLR, 1 cycle: acc_clr=1, IDLE word.
  - ACC_RD, len_kij cycles: CEN_pmem=0, WEN_pmem=1, A_pmem = k*len_nij + (o/out_w + k/3)*in_w + (o%out_w + k%3), for k=0..len_kij-1. acc=1 for k>=1.
  - ACC_TAIL, 1 cycle: acc=1, CEN_pmem=1.
  - Next cycle: out_valid=1, overlapping the next ACC_CLR or the final cycle.
  - done pulses together with the last out_valid.
  - Total: 11*len_onij+1 cycles.
- Address arithmetic: unsigned, truncated to aw bits. At defaults the maximum A_pmem is 8*36+35 = 323, so no overflow.
- start while busy is ignored. A start that coincides with the done cycle is ignored.
- reset asserted mid-pass: inst forced asynchronously to the IDLE word, FSM to IDLE, no done pulse.
- Counters: a single phase counter resets on every state change. o and k counters are used in accumulation only.

Decomposition:
- Package inst_pkg:
  - inst field bit positions and the IDLE word constant.
  - FSM state enum: IDLE, W_L0, W_GAP1, W_LOAD, GAP, A_L0, A_GAP, EXEC, E_GAP, OF_RD, FIN, ACC_CLR, ACC_RD, ACC_TAIL.
- One sub-module: acc_addr_gen. Combinational plus a registered output; takes o and k, produces A_pmem using the constant divide/modulo by out_w and 3.

Test Plan:
- Reset: hold reset=0 mid-EXEC, then release → inst equals the IDLE word (bits 32, 31, 19, 18 = 1, others 0); busy=0, done=0.
- kij pass, kij=2:
  - inst[5] high for exactly 17 cycles with A_xmem 1024..1040.
  - load high for 32 cycles.
  - execute high for 88 cycles.
  - OF_RD A_pmem runs 72..107.
  - done fires 261 cycles after start.
- Accumulation, o=5 → A_pmem sequence 7, 44, 81, 121, 158, 195, 235, 272, 309; acc high for 9 cycles; one out_valid pulse after the ACC_TAIL cycle.
- Full accumulation pass → 16 out_valid pulses spaced 11 cycles apart; last A_pmem = 323; done coincides with the 16th out_valid.
- start with mode=0, kij=9 → err pulse, busy stays 0, inst stays the IDLE word.
- start pulsed during busy and on the done cycle → ignored; the next start after done is accepted normally.
